// File: rtl/binary_frame_streamer.sv
// ---------------------------------------------------------------------------
// binary_frame_streamer
//
// Captures one camera frame, thresholds every RGB pixel to a single bit,
// stores the IMG_COL x IMG_ROW mask in an on-chip 1-bit RAM, then replays it
// as a gap-free raster stream (one bit per clock) preceded by a one-cycle
// start pulse. Feeds the blob counter, which consumes a pixel every cycle.
//
// Optional feature (compile-time macro BFS_MAJORITY_EN):
//   defined   - stored bit for column c >= 2 is majority(t[c-2], t[c-1], t[c])
//               over the current line; columns 0 and 1 store the raw bit.
//   undefined - stored bit is the raw threshold bit.
//
// Parameters:
//   IMG_COL, IMG_ROW      frame geometry
//   R_MIN                 min red for foreground (inclusive)
//   G_MAX, B_MAX          max green / blue for foreground (inclusive)
//
// Ports:
//   i_clk        clock for capture and stream
//   i_rst_n      asynchronous active-low reset
//   i_start      request one capture-and-stream cycle (sampled in IDLE only)
//   i_fval       camera frame valid
//   i_dval       camera pixel valid, qualifies i_r/i_g/i_b
//   i_r/i_g/i_b  12-bit colour components
//   o_valid      one-cycle pulse, stream starts on the next cycle
//   o_seq        mask bit, raster order
//   o_busy       high in every state except IDLE
//   o_short      one-cycle pulse when a frame ends before it is complete
// ---------------------------------------------------------------------------
module binary_frame_streamer #(
  parameter int unsigned IMG_COL = 640,
  parameter int unsigned IMG_ROW = 480,
  parameter logic [11:0] R_MIN   = 12'd2048,
  parameter logic [11:0] G_MAX   = 12'd1024,
  parameter logic [11:0] B_MAX   = 12'd1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_fval,
  input  logic        i_dval,
  input  logic [11:0] i_r,
  input  logic [11:0] i_g,
  input  logic [11:0] i_b,
  output logic        o_valid,
  output logic        o_seq,
  output logic        o_busy,
  output logic        o_short
);

  localparam int unsigned PIX_N  = IMG_COL * IMG_ROW;
  // Address counters must be able to hold PIX_N itself (full / end markers).
  localparam int unsigned ADDR_W = $clog2(PIX_N + 1);
  localparam int unsigned MEM_AW = (PIX_N > 1) ? $clog2(PIX_N) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(PIX_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_SOF,
    S_CAPTURE,
    S_START,
    S_STREAM
  } state_e;

  state_e state_q, state_d;

  logic              fval_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic valid_q;
  logic busy_q;
  logic short_q;
  logic seq_q;

  logic pix_t_c;
  logic wr_bit_c;
  logic wr_en_c;
  logic short_c;
  logic rd_en_c;

  // Frame store: 1 bit per pixel, contents survive reset.
  logic mem [PIX_N];

  // Per-pixel foreground decision, unsigned 12-bit compares.
  always_comb begin
    pix_t_c = (i_r >= R_MIN) && (i_g <= G_MAX) && (i_b <= B_MAX);
  end

`ifdef BFS_MAJORITY_EN
  localparam int unsigned COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

  logic [COL_W-1:0] col_q, col_d;
  // hist_q[0] = t[c-1], hist_q[1] = t[c-2] for the current line.
  logic [1:0]       hist_q, hist_d;

  // Column tracking and filter history; history restarts on every line.
  always_comb begin
    col_d  = col_q;
    hist_d = hist_q;
    if (state_q == S_WAIT_SOF) begin
      col_d  = '0;
      hist_d = '0;
    end else if (wr_en_c) begin
      if (col_q == COL_LAST) begin
        col_d  = '0;
        hist_d = '0;
      end else begin
        col_d  = col_q + COL_W'(1);
        hist_d = {hist_q[0], pix_t_c};
      end
    end
  end

  // Majority of the last three pixels, raw bit for the first two columns.
  always_comb begin
    wr_bit_c = pix_t_c;
    if (col_q >= COL_TWO) begin
      wr_bit_c = (hist_q[1] & hist_q[0]) |
                 (hist_q[1] & pix_t_c)   |
                 (hist_q[0] & pix_t_c);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q  <= '0;
      hist_q <= '0;
    end else begin
      col_q  <= col_d;
      hist_q <= hist_d;
    end
  end
`else
  // Unfiltered: store the threshold bit directly.
  always_comb begin
    wr_bit_c = pix_t_c;
  end
`endif

  // Next-state, counters and strobes.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    wr_en_c   = 1'b0;
    short_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ARM;
        end
      end

      // Never start mid-frame: wait for the camera to go idle first.
      S_ARM: begin
        if (!i_fval) begin
          state_d = S_WAIT_SOF;
        end
      end

      S_WAIT_SOF: begin
        if (i_fval && !fval_q) begin
          state_d   = S_CAPTURE;
          wr_addr_d = '0;
        end
      end

      S_CAPTURE: begin
        if (!i_fval) begin
          short_c = 1'b1;
          state_d = S_WAIT_SOF;
        end else if (i_dval) begin
          wr_en_c   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = S_START;
            rd_addr_d = '0;
          end
        end
      end

      // Address 0 is presented here so bit 0 lands on the first STREAM cycle.
      S_START: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        state_d   = S_STREAM;
      end

      // rd_addr_q runs one ahead of the bit on o_seq; END_ADDR marks the last bit.
      S_STREAM: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (rd_addr_q == END_ADDR) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_en_c = (state_d == S_STREAM);
  end

  // RAM write port (no reset on the array).
  always_ff @(posedge i_clk) begin
    if (wr_en_c) begin
      mem[MEM_AW'(wr_addr_q)] <= wr_bit_c;
    end
  end

  // State, counters and registered outputs; outputs clear at once on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      fval_q    <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      short_q   <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fval_q    <= i_fval;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= (state_d == S_START);
      busy_q    <= (state_d != S_IDLE);
      short_q   <= short_c;
      seq_q     <= rd_en_c ? mem[MEM_AW'(rd_addr_q)] : 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_seq   = seq_q;
  assign o_busy  = busy_q;
  assign o_short = short_q;

endmodule

// File: tb/tb_binary_frame_streamer.sv
// Bench for binary_frame_streamer on a reduced 8x4 frame. Expected masks come
// from a frame-level model (threshold + optional line majority); a negedge
// monitor checks every output cycle and captures the streamed bits.
module tb_binary_frame_streamer;

  localparam int COL = 8;
  localparam int ROW = 4;
  localparam int N   = COL * ROW;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        fval  = 1'b0;
  logic        dval  = 1'b0;
  logic [11:0] r     = '0;
  logic [11:0] g     = '0;
  logic [11:0] b     = '0;
  logic        o_valid, o_seq, o_busy, o_short;

  int total = 0;
  int bad   = 0;
  int mk    = -1;
  int valid_cnt    = 0;
  int short_cnt    = 0;
  int streams_done = 0;

  logic [N-1:0] exp_mask = '0;
  logic [N-1:0] got      = '0;

  binary_frame_streamer #(
    .IMG_COL(COL),
    .IMG_ROW(ROW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_fval (fval),
    .i_dval (dval),
    .i_r    (r),
    .i_g    (g),
    .i_b    (b),
    .o_valid(o_valid),
    .o_seq  (o_seq),
    .o_busy (o_busy),
    .o_short(o_short)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Pixel generator: returns {r, g, b} for pixel p of a frame of the given kind.
  function automatic logic [35:0] pix(input int kind, input int p);
    logic [35:0] fg;
    logic [35:0] bg;
    fg = {12'd4095, 12'd0, 12'd0};
    bg = {12'd0, 12'd0, 12'd0};
    case (kind)
      0: return fg;
      1: return ((p % COL) % 2 == 0) ? fg : bg;
      2: begin
        case (p % 4)
          0:       return {12'd2048, 12'd1024, 12'd1024};
          1:       return {12'd2047, 12'd0, 12'd0};
          2:       return {12'd4095, 12'd1025, 12'd0};
          default: return {12'd4095, 12'd0, 12'd1025};
        endcase
      end
      3: return {12'd0, 12'd4095, 12'd4095};
      default: return (((p * 5 + p / COL) % 3) == 0) ? fg : {12'd100, 12'd0, 12'd0};
    endcase
  endfunction

  // Expected stored mask for the first N accepted pixels of a frame.
  function automatic logic [N-1:0] model(input int kind);
    logic [N-1:0] t;
    logic [N-1:0] m;
    logic [35:0]  px;
    for (int p = 0; p < N; p++) begin
      px   = pix(kind, p);
      t[p] = (px[35:24] >= 12'd2048) && (px[23:12] <= 12'd1024) && (px[11:0] <= 12'd1024);
    end
    m = t;
`ifdef BFS_MAJORITY_EN
    for (int p = 0; p < N; p++) begin
      if ((p % COL) >= 2) begin
        m[p] = (int'(t[p-2]) + int'(t[p-1]) + int'(t[p])) >= 2;
      end
    end
`endif
    return m;
  endfunction

  // Per-cycle output monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk1("rst_valid", o_valid, 1'b0);
      chk1("rst_seq", o_seq, 1'b0);
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_short", o_short, 1'b0);
      mk = -1;
    end else begin
      if (mk >= 0 && mk < N) begin
        chk1($sformatf("seq_bit%0d", mk), o_seq, exp_mask[mk]);
        chk1("stream_busy", o_busy, 1'b1);
        chk1("stream_no_valid", o_valid, 1'b0);
        got[mk] = o_seq;
        mk++;
      end else if (mk == N) begin
        chk1("busy_fall", o_busy, 1'b0);
        chk1("seq_after_stream", o_seq, 1'b0);
        streams_done++;
        mk = -1;
      end else begin
        chk1("seq_idle_zero", o_seq, 1'b0);
        if (o_valid) begin
          chk1("valid_busy", o_busy, 1'b1);
          valid_cnt++;
          mk = 0;
        end
      end
      if (o_short) short_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Idle gap, frame rise with dval low, then npix pixels; leaves fval high.
  task automatic send_pixels(input int kind, input int npix, input int gap);
    fval = 1'b0;
    dval = 1'b0;
    tick();
    tick();
    fval = 1'b1;
    tick();
    for (int p = 0; p < npix; p++) begin
      {r, g, b} = pix(kind, p);
      dval = 1'b1;
      tick();
      dval = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic end_frame;
    dval = 1'b0;
    fval = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_streams(input int target);
    int n = 0;
    while (streams_done < target && n < 1000) begin
      tick();
      n++;
    end
    chkn("stream_complete", streams_done, target);
  endtask

  task automatic wait_bits(input int nbits);
    int n = 0;
    while (mk < nbits && n < 1000) begin
      tick();
      n++;
    end
    chkn("reach_bit", (mk >= nbits) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int s0;
    int sh0;

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk1("reset_valid", o_valid, 1'b0);
    chk1("reset_seq", o_seq, 1'b0);
    chk1("reset_busy", o_busy, 1'b0);
    chk1("reset_short", o_short, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("idle_busy", o_busy, 1'b0);

    // All-foreground frame, dval every other cycle, extra pixels ignored,
    // start during the stream ignored.
    v0 = valid_cnt; s0 = streams_done;
    exp_mask = model(0);
    pulse_start();
    chk1("busy_after_start", o_busy, 1'b1);
    send_pixels(0, N + 4, 1);
    wait_bits(5);
    pulse_start();
    end_frame();
    wait_streams(s0 + 1);
    repeat (3) tick();
    chk1("start_not_queued", o_busy, 1'b0);
    chkn("valid_pulses_A", valid_cnt, v0 + 1);
    chk1("A_bit0", got[0], 1'b1);
    chk1("A_bitlast", got[N-1], 1'b1);

    // Checkerboard columns
    v0 = valid_cnt; s0 = streams_done;
    exp_mask = model(1);
    pulse_start();
    send_pixels(1, N, 0);
    end_frame();
    wait_streams(s0 + 1);
    chkn("valid_pulses_B", valid_cnt, v0 + 1);
    chk1("B_bit0", got[0], 1'b1);
    chk1("B_bit1", got[1], 1'b0);
    chk1("B_bit2", got[2], 1'b1);
    chk1("B_bit7", got[7], 1'b0);

    // Start mid-frame: garbage frame must not be captured; threshold boundaries.
    v0 = valid_cnt; s0 = streams_done;
    exp_mask = model(2);
    fval = 1'b1;
    tick();
    for (int p = 0; p < 5; p++) begin
      {r, g, b} = pix(3, p); dval = 1'b1; tick(); dval = 1'b0; tick();
    end
    pulse_start();
    for (int p = 0; p < 5; p++) begin
      {r, g, b} = pix(3, p); dval = 1'b1; tick(); dval = 1'b0; tick();
    end
    end_frame();
    send_pixels(2, N, 1);
    end_frame();
    wait_streams(s0 + 1);
    chkn("valid_pulses_C", valid_cnt, v0 + 1);
    chk1("C_at_limits", got[0], 1'b1);
    chk1("C_r_below", got[1], 1'b0);
    chk1("C_g_above", got[2], 1'b0);
    chk1("C_b_above", got[3], 1'b0);
    chk1("C_row1_col0", got[8], 1'b1);

    // Short frame then retry on the next full frame.
    v0 = valid_cnt; s0 = streams_done; sh0 = short_cnt;
    exp_mask = model(4);
    pulse_start();
    send_pixels(4, 10, 0);
    end_frame();
    repeat (5) tick();
    chkn("short_pulses", short_cnt, sh0 + 1);
    chkn("short_no_valid", valid_cnt, v0);
    chk1("short_still_busy", o_busy, 1'b1);
    send_pixels(4, N, 0);
    end_frame();
    wait_streams(s0 + 1);
    chkn("short_pulses_after", short_cnt, sh0 + 1);
    chkn("valid_pulses_D", valid_cnt, v0 + 1);

    // Reset in the middle of the stream, then a fresh full capture.
    s0 = streams_done;
    exp_mask = model(1);
    pulse_start();
    send_pixels(1, N, 0);
    wait_bits(10);
    rst_n = 1'b0;
    #1;
    chk1("midrst_valid", o_valid, 1'b0);
    chk1("midrst_seq", o_seq, 1'b0);
    chk1("midrst_busy", o_busy, 1'b0);
    chk1("midrst_short", o_short, 1'b0);
    fval = 1'b0;
    dval = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk1("post_rst_idle", o_busy, 1'b0);
    chkn("aborted_not_complete", streams_done, s0);
    v0 = valid_cnt;
    exp_mask = model(0);
    pulse_start();
    send_pixels(0, N, 0);
    end_frame();
    wait_streams(s0 + 1);
    chkn("valid_pulses_E", valid_cnt, v0 + 1);
    chk1("E_bit0", got[0], 1'b1);
    chk1("E_bitlast", got[N-1], 1'b1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binary_frame_streamer.md
# binary_frame_streamer

Captures one camera frame, thresholds each RGB pixel to a single bit, and stores the 640×480 bit mask in on-chip RAM. It then replays the mask as a gap-free raster stream: one bit per clock, preceded by a one-cycle start pulse. It sits directly upstream of the blob-counting stage and drives that stage's start (`i_valid`) and pixel (`i_seq`) inputs. Camera pixels arrive with blanking gaps, but the blob counter consumes one pixel per cycle unconditionally, so this block buffers the whole frame before streaming.

## Interface
- `IMG_COL`, 640, pixels per line
- `IMG_ROW`, 480, lines per frame
- `R_MIN`, 12'd2048, minimum red for a foreground pixel (inclusive)
- `G_MAX`, 12'd1024, maximum green for a foreground pixel (inclusive)
- `B_MAX`, 12'd1024, maximum blue for a foreground pixel (inclusive)
- `i_clk` in 1: single clock for capture and stream.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_start` in 1: request one capture-and-stream cycle. Sampled only in IDLE.
- `i_fval` in 1: camera frame valid.
- `i_dval` in 1: camera pixel valid, qualifies `i_r`/`i_g`/`i_b`.
- `i_r`, `i_g`, `i_b` in 12 each: pixel colour components.
- `o_valid` out 1: one-cycle pulse; the stream begins on the next cycle.
- `o_seq` out 1: mask bit, raster order, row 0 column 0 first.
- `o_busy` out 1: high in every state except IDLE.
- `o_short` out 1: one-cycle pulse when a frame ends with fewer than IMG_COL×IMG_ROW pixels.

## Operation
- Threshold: t = (`i_r` ≥ R_MIN) && (`i_g` ≤ G_MAX) && (`i_b` ≤ B_MAX). All comparisons are unsigned 12-bit.
- Storage: RAM of IMG_COL×IMG_ROW × 1 bit (307200 words), with a 19-bit write address and a 19-bit read address.
- Synchronous read, latency 1. Contents are not cleared by reset.
- State machine:
  - IDLE: `i_start`=1 → ARM.
  - ARM: wait for `i_fval`=0 → WAIT_SOF. This avoids starting mid-frame.
  - WAIT_SOF: `i_fval` rising (now 1) → CAPTURE, with write address 0 and column 0.
  - CAPTURE: each cycle with `i_fval`&&`i_dval` writes one bit at the write address, then increments the address. The column counter wraps at IMG_COL−1.
  - CAPTURE exit, full frame: when the write address reaches IMG_COL×IMG_ROW, go to START. Further pixels of that frame are ignored.
  - CAPTURE exit, short frame: if `i_fval` falls first, pulse `o_short` and go to WAIT_SOF (retry on the next frame).
  - START: assert `o_valid` for this one cycle and present read address 0 → STREAM.
  - STREAM: `o_seq` = RAM bit k on the k-th STREAM cycle (k=0…307199), with the read address pre-advanced each cycle. After bit 307199 → IDLE.
- `o_seq` = 0 in every state other than STREAM.
- `i_start` asserted while `o_busy` is high is ignored (not queued).
- Camera inputs are ignored outside ARM, WAIT_SOF and CAPTURE.
- Reset mid-operation: every state returns to IDLE and all outputs go to 0 immediately. The next `i_start` begins a fresh capture.

## Timing
- Reset values: `o_valid`=0, `o_seq`=0, `o_busy`=0, `o_short`=0. All outputs are registered.
- `i_start` at cycle n → `o_busy`=1 at n+1.
- `o_valid` is high exactly one cycle, T. Bit 0 appears at T+1 and bit 307199 at T+307200. `o_busy` falls at T+307201.
- The stream has no gaps and no stalls. Total stream latency from `o_valid` is exactly IMG_COL×IMG_ROW+1 cycles.
- Capture latency is unbounded: it depends on camera frame timing.
- When the full-frame condition is met, START is entered on the cycle after the last write.

## Configuration
- Macro `BFS_MAJORITY_EN`.
- Defined: the stored bit for column c ≥ 2 = majority(t[c−2], t[c−1], t[c]) over the current line's thresholded pixels. Columns 0 and 1 store the raw t. The filter history is cleared when the column counter wraps.
  - This adds a 2-entry shift register and no extra latency: the write still happens in the cycle the pixel is accepted.
- Undefined: the stored bit = t.

## Test plan
- Full frame, all pixels R=4095, G=0, B=0, `i_dval` on every other cycle → exactly one `o_valid` pulse, then 307200 consecutive `o_seq`=1, then `o_busy`=0.
- Checkerboard columns (even columns foreground), majority filter disabled → `o_seq` alternates 1,0,1,0… starting at bit 0.
  - Same frame with `BFS_MAJORITY_EN` → columns 0 and 1 give 1,0; columns ≥2 give the majority value (0 at odd c, 1 at even c).
- `i_start` asserted while `i_fval`=1 mid-frame → no writes until `i_fval` falls and rises again; the captured frame equals the second frame.
- Frame of 1000 pixels then `i_fval` falls → `o_short` pulses once, no `o_valid`; the next full frame streams normally.
- `i_rst_n` pulled low at stream bit 1000 → all outputs 0 at once. A later `i_start` yields a fresh full-length stream of exactly 307200 bits.
- Threshold boundaries: R=R_MIN, G=G_MAX, B=B_MAX → 1; R=R_MIN−1 → 0; G=G_MAX+1 → 0.
